// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the streaming pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_e;

    // A P*P window sum of WIDTH-bit samples grows by log2(P*P) bits.
    function automatic int pool_acc_width(input int width, input int p);
        return width + 2 * $clog2(p);
    endfunction

    function automatic bit pool_is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Accumulator RAM: combinational read port, synchronous write port, no reset.
module pool_row_buffer #(
    parameter int DEPTH = 6,
    parameter int DW    = 18,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_stream.sv
// Streaming PxP non-overlapping max/average pooling over a row-major,
// channel-interleaved frame with valid/ready on both sides.
module pool_stream #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int P     = 2,
    parameter int C     = 1
) (
    input  logic             clk,
    input  logic             external_reset,
    input  logic             ce,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             end_op
);

    import pool_pkg::*;

    localparam int LOG2P = $clog2(P);
    localparam int ACCW  = pool_acc_width(WIDTH, P);
    localparam int SHIFT = 2 * LOG2P;
    localparam int DEPTH = (IMG_W / P) * C;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int KW    = (C > 1) ? $clog2(C) : 1;

    generate
        if (P < 2 || !pool_is_pow2(P)) begin : g_bad_p
            $error("pool_stream: P must be a power of two and at least 2");
        end
        if ((IMG_W % P) != 0 || (IMG_H % P) != 0) begin : g_bad_img
            $error("pool_stream: IMG_W and IMG_H must be multiples of P");
        end
        if (C < 1) begin : g_bad_c
            $error("pool_stream: C must be at least 1");
        end
    endgenerate

    pool_state_e state_q, state_d;
    pool_mode_e  mode_q;

    logic [KW-1:0] k_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    logic accept, out_fire;
    logic k_end, x_end, y_end;
    logic win_first, win_last, frame_last;

    assign k_end      = (k_q == KW'(C - 1));
    assign x_end      = (x_q == XW'(IMG_W - 1));
    assign y_end      = (y_q == YW'(IMG_H - 1));
    // P is a power of two, so the window position is the low log2(P) bits.
    assign win_first  = (x_q[LOG2P-1:0] == '0) && (y_q[LOG2P-1:0] == '0);
    assign win_last   = (&x_q[LOG2P-1:0]) && (&y_q[LOG2P-1:0]);
    assign frame_last = k_end && x_end && y_end;

    assign in_ready = external_reset && ce && (state_q != DONE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = ce && out_valid && out_ready;

    // ---------------- accumulator buffer ----------------
    logic [AW-1:0]   idx;
    logic [ACCW-1:0] acc_rd, d_ext, acc_sum, acc_max, combined;
    logic [WIDTH-1:0] result;

    assign idx = AW'(((32'(x_q) >> LOG2P) * C) + 32'(k_q));

    pool_row_buffer #(
        .DEPTH (DEPTH),
        .DW    (ACCW),
        .AW    (AW)
    ) u_acc (
        .clk   (clk),
        .we    (accept && !win_last),
        .waddr (idx),
        .wdata (combined),
        .raddr (idx),
        .rdata (acc_rd)
    );

    // ---------------- combine datapath ----------------
    assign d_ext   = {{(ACCW - WIDTH){in_data[WIDTH-1]}}, in_data};
    assign acc_sum = acc_rd + d_ext;
    assign acc_max = ($signed(acc_rd) > $signed(d_ext)) ? acc_rd : d_ext;

    always_comb begin
        combined = d_ext;
        if (!win_first) combined = (mode_q == POOL_AVG) ? acc_sum : acc_max;
    end

    // Arithmetic shift gives floor division for negative sums.
    assign result = (mode_q == POOL_AVG) ? WIDTH'($signed(combined) >>> SHIFT)
                                         : combined[WIDTH-1:0];

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge external_reset) begin
        if (!external_reset) begin
            k_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (!k_end) begin
                k_q <= k_q + 1'b1;
            end else begin
                k_q <= '0;
                if (!x_end) begin
                    x_q <= x_q + 1'b1;
                end else begin
                    x_q <= '0;
                    y_q <= y_end ? '0 : y_q + 1'b1;
                end
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge external_reset) begin
        if (!external_reset) begin
            state_q <= IDLE;
            mode_q  <= POOL_MAX;
        end else begin
            state_q <= state_d;
            if (accept && state_q == IDLE) mode_q <= pool_mode_e'(mode);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = frame_last ? DONE : RUN;
            RUN:     if (accept && frame_last) state_d = DONE;
            DONE:    if (out_fire && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge external_reset) begin
        if (!external_reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            end_op    <= 1'b0;
        end else begin
            end_op <= out_fire && out_last;
            // A completing sample can only be accepted when the register is free or draining.
            if (accept && win_last) begin
                out_data  <= result;
                out_valid <= 1'b1;
                out_last  <= frame_last;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: 4x4 frame, 2x2 windows, two channels.
module tb_pool_stream;

    localparam int W    = 16;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int P    = 2;
    localparam int C    = 2;
    localparam int NS   = IW * IH * C;

    logic         clk = 1'b0;
    logic         external_reset = 1'b0;
    logic         ce = 1'b1;
    logic         mode = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         end_op;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   frm[NS];
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_mode = 0;
    bit   rand_gaps = 1'b0;
    int   stalls = 0;
    int   end_cnt = 0;
    int   nframes = 0;

    always #5 clk = ~clk;

    pool_stream #(
        .WIDTH (W),
        .IMG_W (IW),
        .IMG_H (IH),
        .P     (P),
        .C     (C)
    ) dut (
        .clk            (clk),
        .external_reset (external_reset),
        .ce             (ce),
        .mode           (mode),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .end_op         (end_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: gather each window's samples from the frame and reduce them.
    task automatic model_frame(input bit avg);
        exp_t e;
        for (int oy = 0; oy < IH / P; oy++)
            for (int ox = 0; ox < IW / P; ox++)
                for (int k = 0; k < C; k++) begin
                    int sum = 0;
                    int mx  = 0;
                    for (int wy = 0; wy < P; wy++)
                        for (int wx = 0; wx < P; wx++) begin
                            int v = frm[(((oy * P + wy) * IW) + ox * P + wx) * C + k];
                            if ((wy == 0 && wx == 0) || v > mx) mx = v;
                            sum += v;
                        end
                    e.d    = W'(avg ? floor_div(sum, P * P) : mx);
                    e.last = (oy == IH / P - 1) && (ox == IW / P - 1) && (k == C - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic fill_ramp();
        for (int p = 0; p < IW * IH; p++) begin
            frm[p * C]     = p + 1;
            frm[p * C + 1] = -(p + 1);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NS; i++) frm[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    // Entered and left at posedge+1.
    task automatic send_sample(input int v);
        int waited = 0;
        if (rand_gaps)
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        in_data  = W'(v);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            waited++;
            if (waited > 2000) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit avg, input bit mix_mode);
        model_frame(avg);
        nframes++;
        mode = avg;
        for (int i = 0; i < NS; i++) begin
            send_sample(frm[i]);
            if (i == 0 && mix_mode) mode = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 4000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_end_op"},    32'(end_op),    32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    // Handshake shaping: 0 = always ready, 1 = random ce/out_ready, 2 = one 5-cycle stall.
    initial begin
        int bp_cnt = 0;
        forever begin
            @(posedge clk); #1;
            case (hs_mode)
                1: begin
                    ce        = ($urandom_range(0, 7) != 0);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    ce = 1'b1;
                    if (out_valid && bp_cnt < 5) begin
                        out_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: begin
                    ce        = 1'b1;
                    out_ready = 1'b1;
                    bp_cnt    = 0;
                end
            endcase
        end
    end

    // Monitor: checks every transfer against the scoreboard and the hold/stall rules.
    initial begin
        bit           prev_hold = 1'b0;
        bit           exp_end = 1'b0;
        bit           nxt_end;
        logic [W-1:0] held_d = '0;
        logic         held_l = 1'b0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!external_reset) begin
                prev_hold = 1'b0;
                exp_end   = 1'b0;
            end else begin
                if (exp_end || end_op) chk("end_op", 32'(end_op), 32'(exp_end));
                if (end_op) end_cnt++;
                if (prev_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data",  32'(out_data),  32'(held_d));
                    chk("hold_last",  32'(out_last),  32'(held_l));
                end
                if (out_valid && !out_ready) begin
                    chk("in_ready_stall", 32'(in_ready), 32'd0);
                    stalls++;
                end
                nxt_end = 1'b0;
                if (out_valid && out_ready && ce) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_last", 32'(out_last), 32'(e.last));
                        nxt_end = out_last;
                    end
                end
                exp_end   = nxt_end;
                prev_hold = out_valid && !(out_ready && ce);
                held_d    = out_data;
                held_l    = out_last;
            end
        end
    end

    initial begin
        int stall_base;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        external_reset = 1'b1;
        @(posedge clk); #1;

        // Ramp: ch0 1..16, ch1 negated; max then average.
        fill_ramp(); send_frame(1'b0, 1'b0); wait_drain();
        fill_ramp(); send_frame(1'b1, 1'b0); wait_drain();

        // Signed window -1..-4 on ch0, saturating extremes on ch1.
        fill_random();
        frm[0] = -1; frm[2] = -2; frm[8] = -3; frm[10] = -4;
        frm[1] = 32767; frm[3] = 32767; frm[9] = 32767; frm[11] = 32767;
        frm[5] = -32768; frm[7] = -32768; frm[13] = -32768; frm[15] = -32768;
        send_frame(1'b0, 1'b0); wait_drain();
        send_frame(1'b1, 1'b0); wait_drain();

        // Random data, modes, gaps, ce and backpressure; mode toggles mid-frame.
        hs_mode = 1; rand_gaps = 1'b1;
        repeat (6) begin
            fill_random();
            send_frame(1'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain();

        // Directed 5-cycle stall on the first pending result.
        hs_mode = 0; rand_gaps = 1'b0;
        @(posedge clk); #1;
        stall_base = stalls;
        hs_mode = 2;
        fill_ramp(); send_frame(1'b0, 1'b0); wait_drain();
        chk("bp_stall_cycles", 32'(stalls - stall_base), 32'd5);
        hs_mode = 0;
        @(posedge clk); #1;

        // Reset after 7 samples: partial frame discarded, fresh frame starts clean.
        fill_ramp();
        mode = 1'b0;
        for (int i = 0; i < 7; i++) send_sample(frm[i]);
        #2;
        external_reset = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        external_reset = 1'b1;
        @(posedge clk); #1;
        fill_ramp(); send_frame(1'b0, 1'b0); wait_drain();

        chk("end_op_count", 32'(end_cnt), 32'(nframes));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming 2-D pooling engine: successor to the fixed max-pooler, generalised to P×P windows, multiple interleaved channels, selectable max/average mode, signed data, and valid/ready handshakes on both sides. Sits between the convolution engine output and the next layer's input FIFO. Consumes one feature-map frame in row-major, channel-interleaved order and emits one pooled value per window per channel.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `IMG_W`, 12: frame width in pixels. Must be a multiple of `P`.
- `IMG_H`, 12: frame height in pixels. Must be a multiple of `P`.
- `P`, 2: window edge and stride; windows do not overlap. Must be a power of two, at least 2. Violations fail elaboration.
- `C`, 1: interleaved channels per pixel, at least 1.
- `clk` in 1: clock, rising edge.
- `external_reset` in 1: asynchronous, active-low reset.
- `ce` in 1: global clock enable. When low, all state freezes and `in_ready`/`out_valid` hold.
- `mode` in 1: 0 = max, 1 = average. Sampled on the first accepted sample of a frame.
- `in_data` in `WIDTH`: input sample.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: engine accepts a sample this cycle.
- `out_data` out `WIDTH`: pooled result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_last` out 1: high together with the final result of a frame.
- `end_op` out 1: one-cycle pulse when the final result of a frame is accepted.

## Operation
- Counters track channel `k` (0..C-1), column `x` (0..IMG_W-1) and row `y` (0..IMG_H-1). `k` wraps into `x`, `x` wraps into `y`, and `y` wraps to 0 at frame end.
- Window coordinates: `wx = x mod P`, `wy = y mod P`. Accumulator index: `(x/P)*C + k`.
- Accumulator buffer: `(IMG_W/P)*C` entries, each `ACCW = WIDTH + 2*log2(P)` bits. Combinational read, write on accept.
- On an accepted sample `d`:
  - First sample of window (`wx==0 && wy==0`): acc ← sign-extended `d`.
  - Otherwise, max mode: acc ← signed max(acc, d).
  - Otherwise, average mode: acc ← acc + d.
  - Last sample of window (`wx==P-1 && wy==P-1`): the combined value goes to the output register instead of the buffer.
- Average result = combined sum arithmetically shifted right by `2*log2(P)`, i.e. floor division. The sum cannot overflow with `ACCW`.
- Max result: low `WIDTH` bits of the combined value.
- Output order: output row, then output column, then channel.
- FSM states:
  - IDLE: counters at 0. First accepted sample latches `mode` and moves to RUN.
  - RUN: moves to DONE when the last sample of the frame is accepted.
  - DONE: holds until the final result is accepted, then pulses `end_op` and returns to IDLE.
- `mode` changes mid-frame are ignored.
- In DONE, `in_ready` is 0.

## Timing
- Accept rule: sample accepted when `in_valid && in_ready && ce`.
- `in_ready = ce && state!=DONE && (!out_valid || out_ready)`. This is a single output register; there is no skid buffer.
- Latency: `out_valid` rises on the cycle after the last sample of a window is accepted.
- Throughput: one sample per cycle with no bubbles while `out_ready` is high.
- While `out_valid && !out_ready`: `out_data` and `out_last` are held stable and no sample is accepted.
- Same cycle: when a result is taken and a new window-completing sample arrives, the new result is loaded with no bubble.
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `end_op`=0, counters 0, state IDLE. `in_ready`=0 while reset is asserted.
- Reset mid-frame: partial windows are discarded. The next sample is treated as pixel (0,0), channel 0. Buffer contents need not be cleared.
- `ce` low in the same cycle as a handshake: no transfer occurs.

## Structure
- Package `pool_pkg`:
  - `pool_mode_e` with values `POOL_MAX`, `POOL_AVG`.
  - `pool_state_e` with values IDLE, RUN, DONE.
  - Helper function for `ACCW`.
- Sub-module `pool_row_buffer`: parametrised depth/width accumulator RAM with combinational read and synchronous write. It is reusable by the later line-buffer work.
- Top level holds the counters, FSM, combine datapath and output register.

## Test plan
- Max mode, `IMG_W=IMG_H=4`, `P=2`, `C=1`, input 1..16 row-major, `out_ready`=1 → outputs 6, 8, 14, 16; `out_last` on 16; `end_op` pulses once.
- Average mode, same input → outputs 3, 5, 11, 13, i.e. floor of 14/4, 22/4, 46/4, 54/4.
- Signed data: window -1,-2,-3,-4 → max gives -1 (0xFFFF); average gives -3 (floor of -2.5).
- `C=2`: channel 0 = 1..16, channel 1 = negated values, max mode → output sequence 6, -1, 8, -3, 14, -9, 16, -11.
- Backpressure: hold `out_ready` low for 5 cycles while a result is pending → `in_ready`=0, `out_data` stable; after release, no sample lost or duplicated. Scoreboard matches the golden model across random `in_valid`/`out_ready`/`ce` gaps.
- Reset asserted after 7 samples → all outputs 0 immediately. A fresh frame of 1..16 then yields 6, 8, 14, 16.
